// File: rtl/probe_io_regs.sv
// probe_io_regs: memory-mapped probe register block on the daisy-chained 16-bit register bus.
//
// Exposes four input probes (read-only snapshots) and four output probes (read/write buffers)
// in an 11-word window starting at BASE_ADDR. Every bus transaction is forwarded with a one-cycle
// registered latency. Reads that hit the window replace the data with the register value.
// Inputs are captured into buffers, and output buffers are driven onto the pins, only on the
// rising edge of the strobe register.
//
// Ports:
//   bus_clk            clock for bus and user logic
//   rst                asynchronous active-high reset
//   probe0..probe3     user input probes (1, 2, 8, 20 bits)
//   probe4..probe7     user output probes (1, 2, 8, 20 bits)
//   addr_i/data_i/rw_i/valid_i   upstream bus (rw_i: 1=write, 0=read)
//   addr_o/data_o/rw_o/valid_o   registered downstream bus
//
// Optional build macro: PROBE_IO_AUTO_SAMPLE_EN
//   When defined, the input buffers load from the probe inputs every cycle, so reads return live
//   values at most one cycle old. The output probes stay strobe-gated either way.
module probe_io_regs #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [0:0]  PROBE4_INIT = 1'b1,
  parameter logic [1:0]  PROBE5_INIT = 2'd3,
  parameter logic [7:0]  PROBE6_INIT = 8'd6,
  parameter logic [19:0] PROBE7_INIT = 20'd7
) (
  input  logic        bus_clk,
  input  logic        rst,

  input  logic        probe0,
  input  logic [1:0]  probe1,
  input  logic [7:0]  probe2,
  input  logic [19:0] probe3,

  output logic        probe4,
  output logic [1:0]  probe5,
  output logic [7:0]  probe6,
  output logic [19:0] probe7,

  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,

  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o
);

  localparam logic [15:0] NumRegs = 16'd11;

  logic [15:0] offset;
  logic        hit;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] rd_data;

  logic        strobe;
  logic        strobe_dly;
  logic        xfer;

  logic        probe0_buf;
  logic [1:0]  probe1_buf;
  logic [7:0]  probe2_buf;
  logic [19:0] probe3_buf;
  logic        probe4_buf;
  logic [1:0]  probe5_buf;
  logic [7:0]  probe6_buf;
  logic [19:0] probe7_buf;

  // Unsigned subtraction keeps the window check a single compare.
  assign offset = addr_i - BASE_ADDR;
  assign hit    = (offset < NumRegs);
  assign rd_en  = valid_i & ~rw_i & hit;
  assign wr_en  = valid_i & rw_i & hit;

  // Transfer fires once per 0->1 edge of the strobe register; holding it high does nothing.
  assign xfer = strobe & ~strobe_dly;

  always_comb begin
    rd_data = 16'h0000;
    case (offset[3:0])
      4'd0:    rd_data = {15'h0000, strobe};
      4'd1:    rd_data = {15'h0000, probe0_buf};
      4'd2:    rd_data = {14'h0000, probe1_buf};
      4'd3:    rd_data = {8'h00, probe2_buf};
      4'd4:    rd_data = probe3_buf[15:0];
      4'd5:    rd_data = {12'h000, probe3_buf[19:16]};
      4'd6:    rd_data = {15'h0000, probe4_buf};
      4'd7:    rd_data = {14'h0000, probe5_buf};
      4'd8:    rd_data = {8'h00, probe6_buf};
      4'd9:    rd_data = probe7_buf[15:0];
      4'd10:   rd_data = {12'h000, probe7_buf[19:16]};
      default: rd_data = 16'h0000;
    endcase
  end

  // Bus pipeline: one-cycle forward, read hits substitute register data.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      addr_o  <= 16'h0000;
      data_o  <= 16'h0000;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      data_o  <= rd_en ? rd_data : data_i;
    end
  end

  // Strobe register and its delayed copy for edge detection.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      strobe     <= 1'b0;
      strobe_dly <= 1'b0;
    end else begin
      strobe_dly <= strobe;
      if (wr_en && (offset[3:0] == 4'd0)) begin
        strobe <= data_i[0];
      end
    end
  end

  // Output buffers: bus writable. A write landing on the transfer edge wins the buffer while the
  // pin below still takes the old buffer value.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      probe4_buf <= PROBE4_INIT;
      probe5_buf <= PROBE5_INIT;
      probe6_buf <= PROBE6_INIT;
      probe7_buf <= PROBE7_INIT;
    end else if (wr_en) begin
      case (offset[3:0])
        4'd6:    probe4_buf <= data_i[0];
        4'd7:    probe5_buf <= data_i[1:0];
        4'd8:    probe6_buf <= data_i[7:0];
        4'd9:    probe7_buf[15:0] <= data_i;
        4'd10:   probe7_buf[19:16] <= data_i[3:0];
        default: ;
      endcase
    end
  end

  // Output pins only move on a transfer.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      probe4 <= PROBE4_INIT;
      probe5 <= PROBE5_INIT;
      probe6 <= PROBE6_INIT;
      probe7 <= PROBE7_INIT;
    end else if (xfer) begin
      probe4 <= probe4_buf;
      probe5 <= probe5_buf;
      probe6 <= probe6_buf;
      probe7 <= probe7_buf;
    end
  end

  // Input snapshot buffers.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      probe0_buf <= 1'b0;
      probe1_buf <= 2'd0;
      probe2_buf <= 8'd0;
      probe3_buf <= 20'd0;
`ifdef PROBE_IO_AUTO_SAMPLE_EN
    end else begin
`else
    end else if (xfer) begin
`endif
      probe0_buf <= probe0;
      probe1_buf <= probe1;
      probe2_buf <= probe2;
      probe3_buf <= probe3;
    end
  end

endmodule

// File: tb/tb_probe_io_regs.sv
// Scoreboard bench for probe_io_regs: stimulus pushes the expected downstream beat into a queue,
// a separate monitor pops and compares whenever valid_o is seen. Pin values are checked directly.
module tb_probe_io_regs;

  localparam logic [15:0] Base = 16'h0040;

  logic        bus_clk = 1'b0;
  logic        rst;
  logic        probe0;
  logic [1:0]  probe1;
  logic [7:0]  probe2;
  logic [19:0] probe3;
  logic        probe4;
  logic [1:0]  probe5;
  logic [7:0]  probe6;
  logic [19:0] probe7;
  logic [15:0] addr_i, data_i, addr_o, data_o;
  logic        rw_i, valid_i, rw_o, valid_o;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  probe_io_regs #(
    .BASE_ADDR  (Base),
    .PROBE4_INIT(1'b1),
    .PROBE5_INIT(2'd3),
    .PROBE6_INIT(8'd6),
    .PROBE7_INIT(20'd7)
  ) dut (
    .bus_clk(bus_clk),
    .rst    (rst),
    .probe0 (probe0),
    .probe1 (probe1),
    .probe2 (probe2),
    .probe3 (probe3),
    .probe4 (probe4),
    .probe5 (probe5),
    .probe6 (probe6),
    .probe7 (probe7),
    .addr_i (addr_i),
    .data_i (data_i),
    .rw_i   (rw_i),
    .valid_i(valid_i),
    .addr_o (addr_o),
    .data_o (data_o),
    .rw_o   (rw_o),
    .valid_o(valid_o)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus beat for a single cycle and record what must come out downstream.
  task automatic bus_op(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic [15:0] exp_data);
    exp_t e;
    @(negedge bus_clk);
    addr_i  = a;
    data_i  = d;
    rw_i    = w;
    valid_i = 1'b1;
    e.addr = a;
    e.data = exp_data;
    e.rw   = w;
    exp_q.push_back(e);
  endtask

  task automatic rd(input int off, input logic [15:0] exp_data);
    bus_op(Base + 16'(off), 16'hA5A5, 1'b0, exp_data);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    bus_op(Base + 16'(off), d, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge bus_clk);
      valid_i = 1'b0;
      rw_i    = 1'b0;
    end
  endtask

  task automatic check_pins(input logic [31:0] e4, input logic [31:0] e5,
                            input logic [31:0] e6, input logic [31:0] e7);
    check("probe4", 32'(probe4), e4);
    check("probe5", 32'(probe5), e5);
    check("probe6", 32'(probe6), e6);
    check("probe7", 32'(probe7), e7);
  endtask

  // Monitor: every downstream beat must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge bus_clk);
      if (rst !== 1'b1 && valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h expected none", addr_o,
                   data_o);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 32'(addr_o), 32'(e.addr));
          check("beat_data", 32'(data_o), 32'(e.data));
          check("beat_rw", 32'(rw_o), 32'(e.rw));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst     = 1'b1;
    addr_i  = 16'h0;
    data_i  = 16'h0;
    rw_i    = 1'b0;
    valid_i = 1'b0;
    probe0  = 1'b0;
    probe1  = 2'd1;
    probe2  = 8'd2;
    probe3  = 20'd3;
    repeat (3) @(negedge bus_clk);
    rst = 1'b0;
    @(negedge bus_clk);

    // Reset state.
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check_pins(32'd1, 32'd3, 32'd6, 32'd7);

    // Input buffers not yet strobed; output buffers at their init values.
    for (int i = 0; i <= 5; i++) rd(i, 16'h0000);
    rd(6, 16'd1);
    rd(7, 16'd3);
    rd(8, 16'd6);
    rd(9, 16'd7);
    rd(10, 16'd0);
    idle(2);

    // Clearing buffers leaves the pins alone.
    for (int i = 6; i <= 10; i++) wr(i, 16'h0000);
    for (int i = 6; i <= 10; i++) rd(i, 16'h0000);
    idle(2);
    check_pins(32'd1, 32'd3, 32'd6, 32'd7);

    // Strobe pulse: pins take buffers, input buffers capture probes.
    wr(0, 16'h0001);
    wr(0, 16'h0000);
    idle(2);
    check_pins(32'd0, 32'd0, 32'd0, 32'd0);
    rd(0, 16'h0000);
    rd(1, 16'd0);
    rd(2, 16'd1);
    rd(3, 16'd2);
    rd(4, 16'd3);
    rd(5, 16'd0);

    // Outside the window (just above and just below): pure pass-through, no state change.
    bus_op(Base + 16'd11, 16'hBEEF, 1'b0, 16'hBEEF);
    bus_op(Base - 16'd1, 16'h1234, 1'b0, 16'h1234);
    bus_op(Base + 16'd11, 16'h5555, 1'b1, 16'h5555);
    bus_op(Base - 16'd1, 16'h0001, 1'b1, 16'h0001);
    rd(0, 16'h0000);
    rd(6, 16'h0000);

    // Read-only offset ignores writes.
    wr(2, 16'hFFFF);
    rd(2, 16'd1);
    idle(2);

    // Second pattern: wider values and write truncation.
    probe0 = 1'b1;
    probe1 = 2'd2;
    probe2 = 8'hA5;
    probe3 = 20'hABCDE;
    wr(6, 16'hFFFF);
    wr(7, 16'hFFFF);
    wr(8, 16'h125A);
    wr(9, 16'h1234);
    wr(10, 16'hFFF5);
    rd(6, 16'd1);
    rd(7, 16'd3);
    rd(8, 16'h005A);
    rd(9, 16'h1234);
    rd(10, 16'h0005);
    rd(1, 16'd0);
    rd(3, 16'd2);
    wr(0, 16'h0001);
    idle(3);
    check_pins(32'd1, 32'd3, 32'h5A, 32'h51234);
    rd(1, 16'd1);
    rd(2, 16'd2);
    rd(3, 16'h00A5);
    rd(4, 16'hBCDE);
    rd(5, 16'h000A);
    idle(1);

    // Strobe held high: no further transfers.
    probe0 = 1'b0;
    probe1 = 2'd0;
    probe2 = 8'h00;
    probe3 = 20'h0;
    wr(6, 16'h0000);
    idle(3);
    rd(1, 16'd1);
    rd(0, 16'h0001);
    idle(1);
    check("held_probe4", 32'(probe4), 32'd1);

    // Re-arm, then a buffer write lands on the transfer edge.
    wr(0, 16'h0000);
    wr(0, 16'h0001);
    wr(8, 16'h0033);
    idle(2);
    check_pins(32'd0, 32'd3, 32'h5A, 32'h51234);
    rd(8, 16'h0033);
    rd(3, 16'h0000);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/probe_io_regs.md
Name: probe_io_regs

Overview:
- Memory-mapped register block exposing four user input probes (read-only) and four user output probes (read/write) over the daisy-chained 16-bit register bus.
- Sits in the bus chain: forwards every transaction to the next core and answers those that fall in its own 11-word address window.
- Inputs are sampled into buffers, and output buffers are driven onto the probe pins, only when a strobe is issued.
- Software sees a coherent snapshot.

Parameters:
- BASE_ADDR, 0, first bus address of the 11-word register window.
- PROBE4_INIT, 1, reset value of probe4 and its buffer.
- PROBE5_INIT, 3, reset value of probe5 and its buffer.
- PROBE6_INIT, 6, reset value of probe6 and its buffer.
- PROBE7_INIT, 7, reset value of probe7 and its buffer.

Ports:
- bus_clk  in  1  single clock for bus and user logic.
- rst  in  1  asynchronous, active-high reset.
- probe0  in  1  user input.
- probe1  in  2  user input.
- probe2  in  8  user input.
- probe3  in  20  user input.
- probe4  out  1  user output.
- probe5  out  2  user output.
- probe6  out  8  user output.
- probe7  out  20  user output.
- addr_i  in  16  bus address in.
- data_i  in  16  bus write data / upstream read data.
- rw_i  in  1  1=write, 0=read.
- valid_i  in  1  transaction strobe, one cycle.
- addr_o  out  16  registered addr_i.
- data_o  out  16  registered data (read result or pass-through).
- rw_o  out  1  registered rw_i.
- valid_o  out  1  registered valid_i.

Behaviour:
- Register map, as offset from BASE_ADDR:
  - 0: strobe (bit0, R/W)
  - 1: probe0_buf (RO)
  - 2: probe1_buf (RO)
  - 3: probe2_buf (RO)
  - 4: probe3_buf[15:0] (RO)
  - 5: probe3_buf[19:16] (RO)
  - 6: probe4_buf (R/W)
  - 7: probe5_buf (R/W)
  - 8: probe6_buf (R/W)
  - 9: probe7_buf[15:0] (R/W)
  - 10: probe7_buf[19:16] (R/W)
- Reads return values zero-extended to 16 bits; unused bits read 0.
- Writes to the RO offsets (1-5) are ignored. Writes store only the implemented bits.
- Bus pipeline, every cycle:
  - addr_o, rw_o and valid_o take last cycle's addr_i, rw_i and valid_i.
  - data_o defaults to data_i.
  - Latency is exactly 1 cycle; no stalls.
- Read hit (valid_i=1, rw_i=0, addr in BASE_ADDR..BASE_ADDR+10): data_o is the addressed register value, registered alongside valid_o.
- Write hit (valid_i=1, rw_i=1, addr in window): the register updates on the same edge that asserts valid_o. It is readable on the next transaction.
- Addresses outside the window pass through untouched; no register changes.
- Strobe:
  - strobe_d is a 1-cycle delayed copy of the strobe register.
  - On the cycle after a 0->1 transition of strobe (strobe & !strobe_d), both transfers happen on one clock edge:
    - probeN_buf <= probeN for inputs 0-3.
    - probeN <= probeN_buf for outputs 4-7.
  - Holding strobe at 1 causes no further transfers. Software writes 1 then 0 to re-arm.
- Output probes change only on a strobe transfer or reset. Writing a buffer never alters the pin directly.
- Reset (async, active-high), asynchronous to bus_clk:
  - strobe, strobe_d and probe0-3 buffers = 0.
  - probe4-7 and their buffers = PROBEx_INIT.
  - addr_o, data_o, rw_o and valid_o = 0.
- Reset mid-transaction drops the transaction: valid_o=0 and no register write occurs.
- Simultaneous bus write to an output buffer and strobe transfer on the same edge: the pin takes the old buffer value, and the buffer takes the bus value.

Optional Feature:
- Macro: PROBE_IO_AUTO_SAMPLE_EN.
- When defined: input buffers 0-3 load from the probe inputs every cycle, so reads return at-most-1-cycle-old live values. Output probes remain strobe-gated.
- When undefined: input buffers load only on a strobe transfer, as described above.

Test Plan:
- Reset, then read offsets 0-5 -> all 0 while probe0..3 = 0,1,2,3 (not yet strobed).
- Read offsets 6-10 after reset -> 1, 3, 6, 7, 0. Pins probe4..7 = 1, 3, 6, 7.
- Write 0 to offsets 6-10 -> buffers read 0; pins still 1, 3, 6, 7.
- Write 1 then 0 to offset 0 -> probe4..7 = 0; probe0..3_buf = 0, 1, 2, 3; reads at offsets 1-5 return 0, 1, 2, 3, 0.
- Read at BASE_ADDR+11 with data_i=0xBEEF -> valid_o one cycle later, data_o=0xBEEF, no state change.
- Write 0xFFFF to offset 2, then read -> returns the previous probe1_buf value; write ignored.
